// File: rtl/gray_input_decoder.sv
// Purpose: synchronize, debounce and Gray-to-binary convert a 4-bit switch input.
// Latency: DEBOUNCE_CYCLES+3 clk edges from the first edge that samples a steady new input.
// Backpressure: none; the downstream stage must take binary_code whenever code_change pulses.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   gray_in      raw, asynchronous, possibly bouncing Gray code
//   binary_code  registered binary value of the last accepted Gray code
//   code_valid   level, set on the first acceptance after reset
//   code_change  one-cycle pulse when binary_code is loaded
module gray_input_decoder #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] gray_in,
    output logic [3:0] binary_code,
    output logic       code_valid,
    output logic       code_change
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        STABLE     = 2'd1,
        SETTLE     = 2'd2
    } state_t;

    state_t        state;
    logic [3:0]    s1;
    logic [3:0]    s2;
    logic [3:0]    cand;
    logic [3:0]    acc;
    logic [CW-1:0] cnt;

    function automatic logic [3:0] gray2bin(input logic [3:0] g);
        logic [3:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Two-flop synchronizer; only s2 is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 4'd0;
            s2 <= 4'd0;
        end else begin
            s1 <= gray_in;
            s2 <= s1;
        end
    end

    wire mismatch = (s2 != cand);
    wire settled  = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= WAIT_FIRST;
            cand        <= 4'd0;
            acc         <= 4'd0;
            cnt         <= '0;
            binary_code <= 4'd0;
            code_valid  <= 1'b0;
            code_change <= 1'b0;
        end else begin
            code_change <= 1'b0;
            case (state)
                WAIT_FIRST: begin
                    if (mismatch) begin
                        cand <= s2;
                        cnt  <= '0;
                    end else if (settled) begin
                        // First acceptance always reports, even if the value is 0.
                        acc         <= cand;
                        binary_code <= gray2bin(cand);
                        code_change <= 1'b1;
                        code_valid  <= 1'b1;
                        cnt         <= '0;
                        state       <= STABLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE: begin
                    cnt <= '0;
                    if (mismatch) begin
                        cand  <= s2;
                        state <= SETTLE;
                    end
                end
                SETTLE: begin
                    if (mismatch) begin
                        cand <= s2;
                        cnt  <= '0;
                    end else if (settled) begin
                        // A bounce that settles back on the accepted value is silent.
                        if (cand != acc) begin
                            acc         <= cand;
                            binary_code <= gray2bin(cand);
                            code_change <= 1'b1;
                        end
                        cnt   <= '0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= WAIT_FIRST;
                end
            endcase
        end
    end

endmodule
